butterfly_sequencer: RTL and testbench
======================================

Name: butterfly_sequencer

Overview:
Single-stage FFT sequencer for one shared, multiplier-based butterfly unit (mult=0 configuration).
- Collects a frame of N complex samples into an internal buffer.
- Issues the N/2 butterfly pairs (k, k+N/2) with twiddle index k, and writes results back in place.
- Streams the transformed frame out.
- Sits between a sample stream source and the next FFT stage / output sink; owns the butterfly's val/rdy handshake.

Parameters:
n, 32, sample/twiddle word width (fixed point, passed through to butterfly).
d, 16, fractional bits (informational; sequencer does no arithmetic on samples).
N, 8, points per frame; power of two, N >= 2.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
recv_val  in  1  input sample valid
recv_rdy  out  1  sequencer accepting input sample
recv_r, recv_c  in  n each  input sample real/imag
send_val  out  1  output sample valid
send_rdy  in  1  sink ready
send_r, send_c  out  n each  output sample real/imag
bf_recv_val  out  1  request to butterfly
bf_recv_rdy  in  1  butterfly ready
bf_ar, bf_ac, bf_br, bf_bc  out  n each  butterfly operands a, b
bf_wr, bf_wc  out  n each  twiddle to butterfly (= tw_r, tw_c)
bf_send_val  in  1  butterfly result valid
bf_send_rdy  out  1  sequencer accepts result
bf_cr, bf_cc, bf_dr, bf_dc  in  n each  butterfly results c = a+wb, d = a-wb
tw_idx  out  $clog2(N/2) (min 1)  twiddle ROM index, combinational lookup
tw_r, tw_c  in  n each  twiddle value for tw_idx, same cycle
busy  out  1  high in ISSUE or OUTPUT

Behaviour:
- Reset is asynchronous. On assertion the block forces:
  - state = LOAD; ld_cnt = iss_cnt = ret_cnt = out_cnt = 0.
  - Outputs: recv_rdy=1, send_val=0, bf_recv_val=0, bf_send_rdy=0, busy=0.
  - Buffer contents are not reset (don't-care).
  - A reset mid-frame discards the frame. In-flight butterfly results arriving after reset are ignored until the next ISSUE.
- LOAD:
  - recv_rdy=1.
  - On recv_val&recv_rdy: buf[ld_cnt] <= {recv_r, recv_c}; ld_cnt++.
  - On the Nth accepted sample: go to ISSUE, clear ld_cnt.
- ISSUE:
  - Request side: bf_recv_val = (iss_cnt < N/2).
  - Operands are combinational from buffer and counter: bf_a = buf[iss_cnt], bf_b = buf[iss_cnt+N/2], tw_idx = iss_cnt, bf_w = tw.
  - On bf_recv_val&bf_recv_rdy: iss_cnt++.
  - Result side: bf_send_rdy=1 throughout ISSUE.
  - On bf_send_val&bf_send_rdy: buf[ret_cnt] <= c; buf[ret_cnt+N/2] <= d; ret_cnt++.
  - Results return in issue order. Pairs are disjoint, so there is no write/read hazard.
  - Issue and return in the same cycle are both performed.
  - When ret_cnt reaches N/2 (after the update): go to OUTPUT.
  - Outstanding requests are not limited by the sequencer; the butterfly's handshake governs them.
- OUTPUT:
  - send_val=1; send = buf[out_cnt].
  - On send_val&send_rdy: out_cnt++.
  - After index N-1 is accepted: go to LOAD, clear all counters. The next frame load may begin the following cycle.
- recv_rdy=0 and bf_send_rdy=0 outside their states. A bf_send_val outside ISSUE is left unaccepted.
- Widths:
  - Counters are $clog2(N)+1 bits; no wrap within a frame.
  - Results are stored unmodified (n bits, modular). No scaling or rounding in the sequencer.
- Latency (N=8, ideal 1-cycle butterfly, no backpressure): N load cycles, then ~N/2 + butterfly latency issue cycles, then N output cycles.

Decomposition:
- Package butterfly_seq_pkg:
  - state enum {LOAD, ISSUE, OUTPUT} (2 bits).
  - localparam helpers for counter width and half-frame size.
- One sub-module, butterfly_seq_buf: N-entry, 2n-bit register file.
  - One write port for loading, two read ports for operands.
  - A dual write port (indices k and k+N/2) for result write-back.
  - One read port for output.
- The FSM and counters stay in butterfly_sequencer.

Test Plan:
1. N=4, n=32, d=16, twiddles all 1.0 (0x00010000,0). Load real samples 1,2,3,4 (Q16.16), imag 0. Output in order is 4,6,-2,-2 (real), imag 0.
2. Same frame with butterfly recv_rdy toggling 1-of-3 cycles and send_val delayed. Outputs are identical; bf_recv_val is held with stable operands until accepted.
3. N=8 with twiddle ROM table k -> (k,0) integer values. tw_idx sequence must be 0,1,2,3, each aligned with the matching bf_a index 0..3.
4. Sink holds send_rdy=0 for 5 cycles mid-output. send_val stays 1 and send_r/c stay stable; no sample is lost or duplicated. recv_rdy stays 0 until the last sample is accepted.
5. Assert reset during ISSUE after 1 of 2 pairs completes (N=4). recv_rdy=1, send_val=0 and bf_recv_val=0 immediately (asynchronous). A fresh frame then produces correct results.
6. Two back-to-back frames with recv_val held high. Second frame loading starts the cycle after the last output handshake; both frames are correct.

Source files
------------

// File: rtl/butterfly_seq_pkg.sv
// Shared types and sizing helpers for the single-stage butterfly sequencer.
package butterfly_seq_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    ISSUE  = 2'd1,
    OUTPUT = 2'd2
  } seq_state_t;

  // Counters carry one extra bit so a full frame count (N) is representable.
  function automatic int cnt_width(input int pts);
    return $clog2(pts) + 1;
  endfunction

  function automatic int addr_width(input int pts);
    return $clog2(pts);
  endfunction

  function automatic int half_size(input int pts);
    return pts / 2;
  endfunction

  function automatic int tw_width(input int pts);
    return (pts > 2) ? $clog2(pts / 2) : 1;
  endfunction

endpackage

// File: rtl/butterfly_seq_buf.sv
// N-entry frame buffer: load port, paired result write-back, operand and output read ports.
module butterfly_seq_buf
  import butterfly_seq_pkg::*;
#(
  parameter  int W  = 64,
  parameter  int N  = 8,
  localparam int AW = addr_width(N)
) (
  input  logic          clk,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_idx,
  input  logic [W-1:0]  ld_data,
  input  logic          res_we,
  input  logic [AW-1:0] res_idx,
  input  logic [W-1:0]  res_lo,
  input  logic [W-1:0]  res_hi,
  input  logic [AW-1:0] op_idx,
  output logic [W-1:0]  op_a,
  output logic [W-1:0]  op_b,
  input  logic [AW-1:0] out_idx,
  output logic [W-1:0]  out_data
);

  localparam int HALF = half_size(N);

  // Contents are deliberately not reset; every entry is rewritten before it is read.
  logic [W-1:0] mem [N];

  // Load and result write-back never happen in the same cycle (different states).
  always_ff @(posedge clk) begin
    if (ld_we) begin
      mem[ld_idx] <= ld_data;
    end
    if (res_we) begin
      mem[res_idx]              <= res_lo;
      mem[res_idx + AW'(HALF)]  <= res_hi;
    end
  end

  assign op_a     = mem[op_idx];
  assign op_b     = mem[op_idx + AW'(HALF)];
  assign out_data = mem[out_idx];

endmodule

// File: rtl/butterfly_sequencer.sv
// Single-stage FFT sequencer: loads a frame, drives N/2 butterflies in place, streams the frame out.
module butterfly_sequencer
  import butterfly_seq_pkg::*;
#(
  parameter  int n   = 32,
  parameter  int d   = 16,
  parameter  int N   = 8,
  localparam int TWW = tw_width(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           recv_val,
  output logic           recv_rdy,
  input  logic [n-1:0]   recv_r,
  input  logic [n-1:0]   recv_c,
  output logic           send_val,
  input  logic           send_rdy,
  output logic [n-1:0]   send_r,
  output logic [n-1:0]   send_c,
  output logic           bf_recv_val,
  input  logic           bf_recv_rdy,
  output logic [n-1:0]   bf_ar,
  output logic [n-1:0]   bf_ac,
  output logic [n-1:0]   bf_br,
  output logic [n-1:0]   bf_bc,
  output logic [n-1:0]   bf_wr,
  output logic [n-1:0]   bf_wc,
  input  logic           bf_send_val,
  output logic           bf_send_rdy,
  input  logic [n-1:0]   bf_cr,
  input  logic [n-1:0]   bf_cc,
  input  logic [n-1:0]   bf_dr,
  input  logic [n-1:0]   bf_dc,
  output logic [TWW-1:0] tw_idx,
  input  logic [n-1:0]   tw_r,
  input  logic [n-1:0]   tw_c,
  output logic           busy
);

  localparam int CW   = cnt_width(N);
  localparam int AW   = addr_width(N);
  localparam int HALF = half_size(N);

  if ((N < 2) || ((N & (N - 1)) != 0)) begin : g_bad_points
    $error("butterfly_sequencer: N must be a power of two and at least 2");
  end
  if ((d < 0) || (d >= n)) begin : g_bad_frac
    $error("butterfly_sequencer: d must lie in [0, n)");
  end

  seq_state_t    state_reg;
  logic [CW-1:0] ld_cnt_reg;
  logic [CW-1:0] iss_cnt_reg;
  logic [CW-1:0] ret_cnt_reg;
  logic [CW-1:0] out_cnt_reg;

  logic ld_fire;
  logic iss_fire;
  logic ret_fire;
  logic out_fire;

  logic [2*n-1:0] op_a;
  logic [2*n-1:0] op_b;
  logic [2*n-1:0] out_data;

  // Handshake outputs are pure decodes of registered state, so reset clears them at once.
  assign recv_rdy    = (state_reg == LOAD);
  assign bf_send_rdy = (state_reg == ISSUE);
  assign send_val    = (state_reg == OUTPUT);
  assign busy        = (state_reg != LOAD);
  assign bf_recv_val = (state_reg == ISSUE) && (iss_cnt_reg < CW'(HALF));

  assign ld_fire  = recv_val & recv_rdy;
  assign iss_fire = bf_recv_val & bf_recv_rdy;
  assign ret_fire = bf_send_val & bf_send_rdy;
  assign out_fire = send_val & send_rdy;

  butterfly_seq_buf #(
    .W (2 * n),
    .N (N)
  ) u_buf (
    .clk      (clk),
    .ld_we    (ld_fire),
    .ld_idx   (ld_cnt_reg[AW-1:0]),
    .ld_data  ({recv_r, recv_c}),
    .res_we   (ret_fire),
    .res_idx  (ret_cnt_reg[AW-1:0]),
    .res_lo   ({bf_cr, bf_cc}),
    .res_hi   ({bf_dr, bf_dc}),
    .op_idx   (iss_cnt_reg[AW-1:0]),
    .op_a     (op_a),
    .op_b     (op_b),
    .out_idx  (out_cnt_reg[AW-1:0]),
    .out_data (out_data)
  );

  assign bf_ar  = op_a[2*n-1:n];
  assign bf_ac  = op_a[n-1:0];
  assign bf_br  = op_b[2*n-1:n];
  assign bf_bc  = op_b[n-1:0];
  assign bf_wr  = tw_r;
  assign bf_wc  = tw_c;
  assign tw_idx = iss_cnt_reg[TWW-1:0];

  assign send_r = out_data[2*n-1:n];
  assign send_c = out_data[n-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= LOAD;
      ld_cnt_reg  <= '0;
      iss_cnt_reg <= '0;
      ret_cnt_reg <= '0;
      out_cnt_reg <= '0;
    end else begin
      unique case (state_reg)
        LOAD: begin
          if (ld_fire) begin
            if (ld_cnt_reg == CW'(N - 1)) begin
              ld_cnt_reg <= '0;
              state_reg  <= ISSUE;
            end else begin
              ld_cnt_reg <= ld_cnt_reg + CW'(1);
            end
          end
        end
        ISSUE: begin
          // Requests and returns are independent; both may advance in one cycle.
          if (iss_fire) begin
            iss_cnt_reg <= iss_cnt_reg + CW'(1);
          end
          if (ret_fire) begin
            ret_cnt_reg <= ret_cnt_reg + CW'(1);
            if (ret_cnt_reg == CW'(HALF - 1)) begin
              state_reg <= OUTPUT;
            end
          end
        end
        OUTPUT: begin
          if (out_fire) begin
            if (out_cnt_reg == CW'(N - 1)) begin
              state_reg   <= LOAD;
              ld_cnt_reg  <= '0;
              iss_cnt_reg <= '0;
              ret_cnt_reg <= '0;
              out_cnt_reg <= '0;
            end else begin
              out_cnt_reg <= out_cnt_reg + CW'(1);
            end
          end
        end
        default: state_reg <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_butterfly_sequencer.sv
// Self-checking bench: table frames, a behavioural butterfly with variable handshakes, and a frame-level FFT stage model.
module tb_butterfly_sequencer;

  localparam int NW  = 32;
  localparam int NP  = 8;
  localparam int H   = NP / 2;
  localparam int TWW = 2;
  localparam int TO  = 400;

  typedef logic [NW-1:0] word_t;
  typedef word_t frame_t [NP];

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic           recv_val, recv_rdy, send_val, send_rdy;
  word_t          recv_r, recv_c, send_r, send_c;
  logic           bf_recv_val, bf_recv_rdy, bf_send_val, bf_send_rdy;
  word_t          bf_ar, bf_ac, bf_br, bf_bc, bf_wr, bf_wc;
  word_t          bf_cr, bf_cc, bf_dr, bf_dc;
  logic [TWW-1:0] tw_idx;
  word_t          tw_r, tw_c;
  logic           busy;

  word_t tw_tab_r [H];
  word_t tw_tab_c [H];
  assign tw_r = tw_tab_r[tw_idx];
  assign tw_c = tw_tab_c[tw_idx];

  butterfly_sequencer #(.n(NW), .d(16), .N(NP)) dut (
    .clk(clk), .reset(reset),
    .recv_val(recv_val), .recv_rdy(recv_rdy), .recv_r(recv_r), .recv_c(recv_c),
    .send_val(send_val), .send_rdy(send_rdy), .send_r(send_r), .send_c(send_c),
    .bf_recv_val(bf_recv_val), .bf_recv_rdy(bf_recv_rdy),
    .bf_ar(bf_ar), .bf_ac(bf_ac), .bf_br(bf_br), .bf_bc(bf_bc),
    .bf_wr(bf_wr), .bf_wc(bf_wc),
    .bf_send_val(bf_send_val), .bf_send_rdy(bf_send_rdy),
    .bf_cr(bf_cr), .bf_cc(bf_cc), .bf_dr(bf_dr), .bf_dc(bf_dc),
    .tw_idx(tw_idx), .tw_r(tw_r), .tw_c(tw_c), .busy(busy)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Q16.16 complex butterfly: c = a + w*b, d = a - w*b, results wrap to 32 bits.
  function automatic void bf_calc(input word_t ar, ac, br, bc, wr, wc,
                                  output word_t cr, cc, dr, dc);
    longint pr, pi;
    pr = (longint'($signed(wr)) * longint'($signed(br)) - longint'($signed(wc)) * longint'($signed(bc))) >>> 16;
    pi = (longint'($signed(wr)) * longint'($signed(bc)) + longint'($signed(wc)) * longint'($signed(br))) >>> 16;
    cr = ar + word_t'(pr);
    cc = ac + word_t'(pi);
    dr = ar - word_t'(pr);
    dc = ac - word_t'(pi);
  endfunction

  // Reference: one radix-2 stage over the whole frame, pairs (k, k+N/2) with twiddle k.
  function automatic void fft_ref(input frame_t ir, ic, output frame_t er, ec);
    for (int k = 0; k < H; k++)
      bf_calc(ir[k], ic[k], ir[k+H], ic[k+H], tw_tab_r[k], tw_tab_c[k],
              er[k], ec[k], er[k+H], ec[k+H]);
  endfunction

  // ---------------- behavioural butterfly unit ----------------
  typedef struct { word_t cr, cc, dr, dc; int rdy_at; } res_t;
  res_t   rq[$];
  int     cyc = 0;
  int     rdy_mode = 0;   // 0: always ready, 1: ready 1-of-3 cycles, 2: random
  int     lat = 1;        // 0 selects a random latency of 1..3 per request
  int     bf_k = 0;
  int     ret_seen = 0;
  frame_t cur_r, cur_c;
  logic   prev_wait = 1'b0;
  logic [127:0] prev_ops;

  always @(negedge clk) begin
    res_t r;
    cyc++;
    if (reset) begin
      rq.delete();
      bf_send_val = 1'b0;
      bf_recv_rdy = 1'b0;
      bf_k = 0;
      prev_wait = 1'b0;
    end else begin
      case (rdy_mode)
        0:       bf_recv_rdy = 1'b1;
        1:       bf_recv_rdy = (cyc % 3 == 0);
        default: bf_recv_rdy = 1'($urandom_range(0, 1));
      endcase
      if (rq.size() > 0 && rq[0].rdy_at <= cyc) begin
        bf_send_val = 1'b1;
        {bf_cr, bf_cc, bf_dr, bf_dc} = {rq[0].cr, rq[0].cc, rq[0].dr, rq[0].dc};
      end else begin
        bf_send_val = 1'b0;
      end
      if (prev_wait)
        check("bf_hold", {bf_recv_val, bf_ar, bf_ac, bf_br, bf_bc}, {1'b1, prev_ops});
      if (bf_recv_val && bf_recv_rdy) begin
        check("bf_tw", {tw_idx, bf_wr, bf_wc}, {TWW'(bf_k), tw_tab_r[bf_k], tw_tab_c[bf_k]});
        check("bf_ops", {bf_ar, bf_ac, bf_br, bf_bc},
              {cur_r[bf_k], cur_c[bf_k], cur_r[bf_k+H], cur_c[bf_k+H]});
        bf_calc(bf_ar, bf_ac, bf_br, bf_bc, bf_wr, bf_wc, r.cr, r.cc, r.dr, r.dc);
        r.rdy_at = cyc + ((lat == 0) ? int'($urandom_range(1, 3)) : lat);
        rq.push_back(r);
        bf_k = (bf_k + 1) % H;
      end
      prev_wait = bf_recv_val && !bf_recv_rdy;
      prev_ops  = {bf_ar, bf_ac, bf_br, bf_bc};
      if (bf_send_val && bf_send_rdy) begin
        void'(rq.pop_front());
        ret_seen++;
      end
    end
  end

  // ---------------- source / sink ----------------
  task automatic load_frame(input frame_t fr, input frame_t fc, input bit hold);
    for (int i = 0; i < NP; i++) begin
      int t = 0;
      recv_val = 1'b1;
      recv_r = fr[i];
      recv_c = fc[i];
      while (!recv_rdy && t < TO) begin @(negedge clk); t++; end
      check("recv_rdy_wait", recv_rdy, 1'b1);
      @(negedge clk);
    end
    if (!hold) recv_val = 1'b0;
  endtask

  task automatic collect_frame(output frame_t orr, output frame_t oc, input int stall_at);
    logic [63:0] sr;
    send_rdy = 1'b1;
    for (int i = 0; i < NP; i++) begin
      int t = 0;
      while (!send_val && t < TO) begin @(negedge clk); t++; end
      check("send_val_wait", send_val, 1'b1);
      if (i == stall_at) begin
        send_rdy = 1'b0;
        sr = {send_r, send_c};
        repeat (5) begin
          @(negedge clk);
          check("stall_hold", {send_val, recv_rdy, busy, send_r, send_c}, {3'b101, sr});
        end
        send_rdy = 1'b1;
      end
      orr[i] = send_r;
      oc[i]  = send_c;
      @(negedge clk);
    end
    send_rdy = 1'b0;
    check("reload_rdy", recv_rdy, 1'b1);
  endtask

  task automatic compare_frame(input string nm, input frame_t ar, ac, er, ec);
    for (int i = 0; i < NP; i++)
      check(nm, {ar[i], ac[i]}, {er[i], ec[i]});
  endtask

  task automatic rand_frame(output frame_t r, output frame_t c);
    for (int i = 0; i < NP; i++) begin
      r[i] = $urandom;
      c[i] = $urandom;
    end
  endtask

  task automatic set_tw_unity();
    for (int k = 0; k < H; k++) begin
      tw_tab_r[k] = 32'h0001_0000;
      tw_tab_c[k] = '0;
    end
  endtask

  // ---------------- table vectors (twiddle = 1.0, values in whole units) ----------------
  typedef struct { int in_r[NP]; int in_c[NP]; int ex_r[NP]; int ex_c[NP]; } vec_t;
  vec_t vt[3];

  initial begin
    frame_t ir, ic, er, ec, orr, oc, br, bc;
    int t;
    int base;

    vt[0].in_r = '{1, 2, 3, 4, 5, 6, 7, 8};
    vt[0].in_c = '{0, 0, 0, 0, 0, 0, 0, 0};
    vt[0].ex_r = '{6, 8, 10, 12, -4, -4, -4, -4};
    vt[0].ex_c = '{0, 0, 0, 0, 0, 0, 0, 0};
    vt[1].in_r = '{0, 0, 0, 0, 0, 0, 0, 0};
    vt[1].in_c = '{1, 2, 3, 4, 5, 6, 7, 8};
    vt[1].ex_r = '{0, 0, 0, 0, 0, 0, 0, 0};
    vt[1].ex_c = '{6, 8, 10, 12, -4, -4, -4, -4};
    vt[2].in_r = '{10, 0, -5, 7, 2, 4, 6, -7};
    vt[2].in_c = '{0, 1, 2, 3, 4, 5, 6, 7};
    vt[2].ex_r = '{12, 4, 1, 0, 8, -4, -11, 14};
    vt[2].ex_c = '{4, 6, 8, 10, -4, -4, -4, -4};

    recv_val = 1'b0; send_rdy = 1'b0; recv_r = '0; recv_c = '0;
    bf_recv_rdy = 1'b0; bf_send_val = 1'b0;
    bf_cr = '0; bf_cc = '0; bf_dr = '0; bf_dc = '0;
    set_tw_unity();

    #1 reset = 1'b1;
    #1;
    check("reset_outputs", {recv_rdy, send_val, bf_recv_val, bf_send_rdy, busy}, 5'b10000);
    @(posedge clk); #3 reset = 1'b0;
    @(negedge clk);

    // Table frames, ideal butterfly.
    for (int v = 0; v < 3; v++) begin
      for (int i = 0; i < NP; i++) begin
        ir[i] = word_t'(vt[v].in_r[i] * 65536);
        ic[i] = word_t'(vt[v].in_c[i] * 65536);
        er[i] = word_t'(vt[v].ex_r[i] * 65536);
        ec[i] = word_t'(vt[v].ex_c[i] * 65536);
      end
      cur_r = ir; cur_c = ic;
      load_frame(ir, ic, 1'b0);
      collect_frame(orr, oc, -1);
      compare_frame($sformatf("table_v%0d", v), orr, oc, er, ec);
      $display("[TB] table vector %0d done", v);
    end

    // Same first frame with a sparse-ready, slow butterfly.
    rdy_mode = 1; lat = 3;
    for (int i = 0; i < NP; i++) begin
      ir[i] = word_t'(vt[0].in_r[i] * 65536);
      ic[i] = '0;
      er[i] = word_t'(vt[0].ex_r[i] * 65536);
      ec[i] = '0;
    end
    cur_r = ir; cur_c = ic;
    load_frame(ir, ic, 1'b0);
    collect_frame(orr, oc, -1);
    compare_frame("slow_bf", orr, oc, er, ec);
    $display("[TB] slow butterfly frame done");

    // Index-valued twiddles, random samples, random handshakes, sink stall mid-output.
    for (int k = 0; k < H; k++) begin
      tw_tab_r[k] = word_t'(k * 65536);
      tw_tab_c[k] = '0;
    end
    rdy_mode = 2; lat = 0;
    rand_frame(ir, ic);
    fft_ref(ir, ic, er, ec);
    cur_r = ir; cur_c = ic;
    load_frame(ir, ic, 1'b0);
    collect_frame(orr, oc, 3);
    compare_frame("tw_index_stall", orr, oc, er, ec);
    $display("[TB] indexed twiddle + stall frame done");

    // Back-to-back frames with recv_val held high between them, random complex twiddles.
    for (int k = 0; k < H; k++) begin
      tw_tab_r[k] = $urandom;
      tw_tab_c[k] = $urandom;
    end
    rand_frame(ir, ic);
    rand_frame(br, bc);
    cur_r = ir; cur_c = ic;
    load_frame(ir, ic, 1'b1);
    collect_frame(orr, oc, -1);
    fft_ref(ir, ic, er, ec);
    compare_frame("b2b_first", orr, oc, er, ec);
    cur_r = br; cur_c = bc;
    load_frame(br, bc, 1'b0);
    collect_frame(orr, oc, -1);
    fft_ref(br, bc, er, ec);
    compare_frame("b2b_second", orr, oc, er, ec);
    $display("[TB] back-to-back frames done");

    // Reset in the middle of ISSUE, right after the first result returns.
    rdy_mode = 1; lat = 1;
    rand_frame(ir, ic);
    cur_r = ir; cur_c = ic;
    base = ret_seen;
    load_frame(ir, ic, 1'b0);
    t = 0;
    while (ret_seen < base + 1 && t < TO) begin @(posedge clk); t++; end
    check("pre_reset_issue", {busy, bf_recv_val, bf_send_rdy}, 3'b111);
    #3 reset = 1'b1;
    #1;
    check("async_reset", {recv_rdy, send_val, bf_recv_val, bf_send_rdy, busy}, 5'b10000);
    @(posedge clk); #3 reset = 1'b0;
    @(negedge clk);
    rdy_mode = 2; lat = 0;
    rand_frame(ir, ic);
    fft_ref(ir, ic, er, ec);
    cur_r = ir; cur_c = ic;
    load_frame(ir, ic, 1'b0);
    collect_frame(orr, oc, -1);
    compare_frame("after_reset", orr, oc, er, ec);
    $display("[TB] post-reset frame done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
